cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) between the five execution units (ADD1..ADD3, MUL1..MUL2) of the Tomasulo core. Each unit hands its finished result and ROB tag to a one-entry holding slot. A round-robin arbiter then broadcasts one slot per cycle on a registered CDB to the reservation stations, register file and order manager. Back-pressure to each unit is a per-source ready.

Parameters:
NUM_SRC, 5, number of requesting execution units; index 0..2 = ADD1..ADD3, 3..4 = MUL1..MUL2
DATA_W, 32, result width
TAG_W, 4, ROB/rename tag width
SRC_W, 3, width of source index, must satisfy 2**SRC_W >= NUM_SRC

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all held results (recovery); synchronous
src_valid  in  NUM_SRC  per-unit result valid
src_ready  out  NUM_SRC  per-unit slot can accept this cycle
src_result  in  NUM_SRC*DATA_W  flattened results, source i at [i*DATA_W +: DATA_W]
src_tag  in  NUM_SRC*TAG_W  flattened tags, source i at [i*TAG_W +: TAG_W]
cdb_valid  out  1  broadcast valid (registered)
cdb_data  out  DATA_W  broadcast result (registered)
cdb_tag  out  TAG_W  broadcast tag (registered)
cdb_src  out  SRC_W  index of broadcasting unit (registered)

Behaviour:
- Reset (rst_n low, async): all slot full bits 0; rr_ptr = 0; cdb_valid = 0; cdb_data = 0; cdb_tag = 0; cdb_src = 0.
- Slot i state: full[i], data[i], tag[i].
- Accept: src_ready[i] = ~full[i] | grant[i]. This is combinational, so one result per cycle per source is sustained.
- Capture: src_valid[i] & src_ready[i] at an edge loads the slot and sets full[i]=1.
- src_valid[i] with src_ready[i]=0 is a protocol violation. The input is ignored and the slot is unchanged; the bench flags it.
- Arbitration (combinational, over full[]): scan indices rr_ptr, rr_ptr+1, ... mod NUM_SRC; the first full slot wins (grant one-hot or zero).
- Broadcast edge with a winner w:
  - cdb_valid<=1, cdb_data<=data[w], cdb_tag<=tag[w], cdb_src<=w.
  - full[w] cleared unless reloaded in the same cycle.
  - rr_ptr <= (w+1) mod NUM_SRC.
- Edge with no winner: cdb_valid<=0. cdb_data/tag/src hold their last values. rr_ptr unchanged.
- Latency: a result accepted in cycle 0 occupies its slot in cycle 1. If granted in cycle 1, cdb_valid is high in cycle 2. Minimum 2 cycles.
- Fairness: a full slot waits at most NUM_SRC-1 grants before it wins.
- Simultaneous grant and reload of the same slot: the new data replaces the old and full stays 1. The old data goes onto the CDB.
- rr_ptr wrap: after w = NUM_SRC-1 the pointer returns to 0.
- flush=1 at an edge: all full<=0, cdb_valid<=0, src inputs that cycle are dropped, rr_ptr unchanged. src_ready stays driven by the normal equation; accepted data is discarded.
- Reset asserted mid-operation: held results are lost immediately and all outputs return to reset values asynchronously.
- cdb_valid never stays high for two cycles with the same slot unless that slot was reloaded.

Decomposition:
- Shared package/include (core_defs): NUM_SRC, DATA_W, TAG_W, SRC_W, source index constants SRC_ADD1=0, SRC_ADD2=1, SRC_ADD3=2, SRC_MUL1=3, SRC_MUL2=4.
- One sub-module, rr_arbiter: purely combinational rotating-priority pick.
  - Inputs: req[NUM_SRC], ptr[SRC_W].
  - Outputs: grant one-hot, grant_idx, any_grant.
- Slots, pointer and CDB registers live in cdb_arbiter.

Test Plan:
- Reset: hold rst_n=0 with src_valid=5'b11111 -> cdb_valid=0, src_ready=5'b11111, cdb_data=0. Release, then no inputs for 3 cycles -> cdb_valid stays 0.
- Single result: cycle 0 src_valid=5'b00001, result 0x0000_00AA, tag 3 -> cycle 2 cdb_valid=1, data 0xAA, tag 3, src 0. Cycle 3 cdb_valid=0.
- All five valid in cycle 0, tags 1..5 -> cycles 2..6 broadcast src 0,1,2,3,4 in order, one per cycle. src_ready=0 for the waiting slots; cycle 7 cdb_valid=0.
- Fairness: MUL2 (4) and ADD1 (0) both send back-to-back every cycle -> CDB alternates src 4,0,4,0 (or 0,4,...) with no source granted twice in a row. Neither source ever waits more than 1 grant.
- Same-slot reload: ADD2 sends tag 6, then tag 7 in the cycle it is granted -> CDB shows tag 6, then tag 7 on a later grant, with full[1] continuous.
- Flush: load slots 0,3 (tags 8,9), assert flush in the next cycle -> cdb_valid=0 the following cycle and no tag 8/9 ever appears. A new result after flush broadcasts normally in 2 cycles.

Source files
------------

// File: rtl/core_defs.sv
// Shared constants for the CDB arbiter: sizes and execution-unit source indices.
package core_defs;
  localparam int NUM_SRC = 5;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int SRC_W   = 3;

  localparam logic [SRC_W-1:0] SRC_ADD1 = 3'd0;
  localparam logic [SRC_W-1:0] SRC_ADD2 = 3'd1;
  localparam logic [SRC_W-1:0] SRC_ADD3 = 3'd2;
  localparam logic [SRC_W-1:0] SRC_MUL1 = 3'd3;
  localparam logic [SRC_W-1:0] SRC_MUL2 = 3'd4;
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority pick: the first set req at or after ptr (mod NUM_SRC) wins.
module rr_arbiter #(
  parameter int NUM_SRC = 5,
  parameter int SRC_W   = 3
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [SRC_W-1:0]   grant_idx,
  output logic               any_grant
);

  // Scan from the farthest offset back to ptr so the closest request wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = SRC_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per execution unit, round-robin
// broadcast of one slot per cycle onto a registered CDB.
module cdb_arbiter
  import core_defs::*;
#(
  parameter int NUM_SRC = core_defs::NUM_SRC,
  parameter int DATA_W  = core_defs::DATA_W,
  parameter int TAG_W   = core_defs::TAG_W,
  parameter int SRC_W   = core_defs::SRC_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_result,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [SRC_W-1:0]          cdb_src
);

  logic [NUM_SRC-1:0]             full;
  logic [NUM_SRC-1:0][DATA_W-1:0] data_q;
  logic [NUM_SRC-1:0][TAG_W-1:0]  tag_q;
  logic [SRC_W-1:0]               rr_ptr;
  logic [NUM_SRC-1:0]             grant;
  logic [SRC_W-1:0]               grant_idx;
  logic                           any_grant;
  logic [NUM_SRC-1:0]             take;
  logic [SRC_W-1:0]               ptr_next;

  rr_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_rr (
    .req       (full),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A slot being drained this cycle can take a new result, sustaining one per cycle.
  assign src_ready = ~full | grant;
  assign take      = src_valid & src_ready;
  assign ptr_next  = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);

  // Slot fill/drain; a reload in the grant cycle keeps the slot full with the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= '0;
      data_q <= '0;
      tag_q  <= '0;
    end else if (flush) begin
      full <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (take[i]) begin
          full[i]   <= 1'b1;
          data_q[i] <= src_result[i*DATA_W +: DATA_W];
          tag_q[i]  <= src_tag[i*TAG_W +: TAG_W];
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Registered broadcast; payload holds its last value on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_tag   <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (any_grant) begin
      cdb_valid <= 1'b1;
      cdb_data  <= data_q[grant_idx];
      cdb_tag   <= tag_q[grant_idx];
      cdb_src   <= grant_idx;
      rr_ptr    <= ptr_next;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule
